// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter_pkg
// Description : Shared encodings and width helpers for the class-SRAM
//               arbiter and its tag FIFO.
//               - size_e       : class-SRAM transfer size encoding
//               - ch_width()   : bits needed to name one master channel
//               - tag_width()  : tag FIFO entry width {ch, discard}
// Revision    : 1.0 - initial release
// ============================================================================
package sram_like_arbiter_pkg;

  // Transfer size as carried on m_size / s_size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Width of the discard flag stored alongside each channel index.
  localparam int TAG_FLAG_W = 1;

  // A single-channel build still needs a 1-bit index so vectors stay legal.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int tag_width(input int num_ch);
    return ch_width(num_ch) + TAG_FLAG_W;
  endfunction

endpackage : sram_like_arbiter_pkg
`default_nettype wire

// File: rtl/sram_like_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter_tag_fifo
// Description : In-order tag FIFO for accepted class-SRAM requests. Each
//               entry records the owning channel and a discard flag. A flush
//               vector marks every stored entry of the flagged channels as
//               discarded; the head view is also corrected combinationally so
//               a head popped in the flush cycle is already suppressed.
// Ports       : clk, reset          clock / synchronous active-high reset
//               push, push_ch       enqueue a tag for channel push_ch
//               pop                 dequeue the head (caller guarantees !empty)
//               flush[NUM_CH]       per-channel discard request
//               head_ch             channel of the head entry
//               head_discard        head response must not reach its master
//               count, full, empty  occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter_tag_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [CH_W-1:0]            push_ch,
  input  logic                       pop,
  input  logic [NUM_CH-1:0]          flush,
  output logic [CH_W-1:0]            head_ch,
  output logic                       head_discard,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CH_W-1:0]  ch_mem [DEPTH];
  logic [DEPTH-1:0] disc_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      disc_mem <= '0;
    end else begin
      // Flush is applied to every slot; stale slots outside the live window
      // are rewritten with discard=0 on their next push, so this is harmless.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[ch_mem[i]]) begin
          disc_mem[i] <= 1'b1;
        end
      end
      // The push is written after the flush loop so an entry accepted in the
      // flush cycle keeps discard=0: it belongs to the new request stream.
      if (push) begin
        ch_mem[wr_ptr]   <= push_ch;
        disc_mem[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    head_ch      = ch_mem[rd_ptr];
    head_discard = disc_mem[rd_ptr] | flush[head_ch];
    count        = count_q;
    full         = (count_q == CNT_W'(DEPTH));
    empty        = (count_q == '0);
  end

endmodule : sram_like_arbiter_tag_fifo
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : NUM_CH-master to single-slave arbiter for the class-SRAM
//               req/addr_ok/data_ok bus. Grants one master per cycle
//               (round-robin or fixed priority), holds the grant while the
//               slave withholds addr_ok, records accepted requests in an
//               in-order tag FIFO and routes each data_ok back to its owner.
//               Per-channel flush drops outstanding responses of a channel.
// Ports       : clk, reset                 clock / sync active-high reset
//               m_req/m_wr/m_size/m_addr/m_wstrb/m_wdata   master requests,
//                                          channel i in slice i
//               m_addr_ok[NUM_CH]          request accepted this cycle
//               m_data_ok[NUM_CH]          response for channel i this cycle
//               m_rdata                    broadcast read data
//               flush[NUM_CH]              discard outstanding responses
//               s_req/s_wr/s_size/s_addr/s_wstrb/s_wdata  slave request
//               s_addr_ok, s_data_ok, s_rdata             slave handshake
//               outst_cnt                  tag FIFO occupancy
//               err_unexp                  sticky: data_ok with no tag
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int RR_MODE   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  // master side
  input  logic [NUM_CH-1:0]            m_req,
  input  logic [NUM_CH-1:0]            m_wr,
  input  logic [2*NUM_CH-1:0]          m_size,
  input  logic [ADDR_W*NUM_CH-1:0]     m_addr,
  input  logic [DATA_W/8*NUM_CH-1:0]   m_wstrb,
  input  logic [DATA_W*NUM_CH-1:0]     m_wdata,
  output logic [NUM_CH-1:0]            m_addr_ok,
  output logic [NUM_CH-1:0]            m_data_ok,
  output logic [DATA_W-1:0]            m_rdata,
  input  logic [NUM_CH-1:0]            flush,
  // slave side
  output logic                         s_req,
  output logic                         s_wr,
  output logic [1:0]                   s_size,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic                         s_addr_ok,
  input  logic                         s_data_ok,
  input  logic [DATA_W-1:0]            s_rdata,
  // status
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_unexp
);

  localparam int CH_W   = ch_width(NUM_CH);
  localparam int STRB_W = DATA_W / 8;

  // Request-lock state: LOCKED means a request is on the bus without
  // addr_ok and must be presented unchanged until the slave takes it.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state_q;
  logic [CH_W-1:0] lock_ch_q;
  logic [CH_W-1:0] rr_ptr_q;
  logic            err_q;

  logic            grant_valid;
  logic [CH_W-1:0] grant_ch;
  logic [CH_W-1:0] cand;
  logic            accept;
  logic            pop;

  logic                             fifo_full;
  logic                             fifo_empty;
  logic [CH_W-1:0]                  head_ch;
  logic                             head_discard;
  logic [$clog2(MAX_OUTST):0]       fifo_count;

  // --------------------------------------------------------------------------
  // Grant selection. While locked the grant is pinned to the locked channel
  // regardless of m_req; a master that drops req while locked is in error.
  // Otherwise search upward from rr_ptr (round-robin) or from 0 (fixed).
  // --------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    if (state_q == ST_LOCKED) begin
      grant_valid = 1'b1;
      grant_ch    = lock_ch_q;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (RR_MODE != 0) begin
          cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
        end else begin
          cand = CH_W'(k);
        end
        if (!grant_valid && m_req[cand]) begin
          grant_valid = 1'b1;
          grant_ch    = cand;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slave request mux. A full tag FIFO blocks the request outright, even if a
  // response pops in the same cycle, so the FIFO never relies on push-on-pop.
  // --------------------------------------------------------------------------
  always_comb begin
    s_req   = grant_valid & ~fifo_full;
    s_wr    = 1'b0;
    s_size  = '0;
    s_addr  = '0;
    s_wstrb = '0;
    s_wdata = '0;
    if (s_req) begin
      s_wr    = m_wr[grant_ch];
      s_size  = m_size[int'(grant_ch)*2 +: 2];
      s_addr  = m_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
      s_wstrb = m_wstrb[int'(grant_ch)*STRB_W +: STRB_W];
      s_wdata = m_wdata[int'(grant_ch)*DATA_W +: DATA_W];
    end
  end

  assign accept = s_req & s_addr_ok;
  // An unexpected data_ok (empty FIFO) must not disturb the pointers.
  assign pop    = s_data_ok & ~fifo_empty;

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    if (accept) begin
      m_addr_ok = NUM_CH'(1) << grant_ch;
    end
    if (pop && !head_discard) begin
      m_data_ok = NUM_CH'(1) << head_ch;
    end
  end

  // Zero-latency pass-through; only meaningful alongside m_data_ok.
  assign m_rdata   = s_rdata;
  assign outst_cnt = fifo_count;
  assign err_unexp = err_q;

  // --------------------------------------------------------------------------
  // Lock, round-robin pointer and sticky error.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_req && !s_addr_ok) begin
            state_q   <= ST_LOCKED;
            lock_ch_q <= grant_ch;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (accept && (RR_MODE != 0)) begin
        rr_ptr_q <= CH_W'((int'(grant_ch) + 1) % NUM_CH);
      end
      if (s_data_ok && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  sram_like_arbiter_tag_fifo #(
    .DEPTH  (MAX_OUTST),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_tag_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (accept),
    .push_ch      (grant_ch),
    .pop          (pop),
    .flush        (flush),
    .head_ch      (head_ch),
    .head_discard (head_discard),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

endmodule : sram_like_arbiter
`default_nettype wire
